hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_pkg.sv | 18 +
 rtl/sat_counter.sv | 21 ++
 rtl/hazard_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Purpose: shared types and constants for the pipeline hazard unit.
// Contents: FSM state encoding and the forwarding-mux select codes.
// Used by: hazard_unit (and any datapath that decodes ForwardAE/BE).
package hazard_pkg;

  // Memory-handshake FSM states. ERROR is only left through reset.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazard_state_t;

  // Execute-stage operand source selects.
  localparam logic [1:0] FWD_RF = 2'b00;  // register file read
  localparam logic [1:0] FWD_W  = 2'b01;  // Writeback result
  localparam logic [1:0] FWD_M  = 2'b10;  // Memory-stage ALU result

endpackage

// File: rtl/sat_counter.sv
// Purpose: saturating up-counter for performance statistics.
// Latency: count_o reflects inc_i one cycle later; never wraps, sticks at all-ones.
// Ports: clk_i, rst_i (sync, active-high), inc_i -> count_o[WIDTH-1:0].
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Purpose: RISC-V 5-stage hazard unit: forwarding, load-use stall, branch flush, memory-wait freeze with timeout.
// Latency: forward/stall/flush outputs are combinational (Mealy); MemTimeout_o and counters are registered.
// Ports: D/E/M/W register indices and enables in; ForwardAE/BE, Stall F/D/E/M, Flush D/E/W, MemTimeout, counters out.
module hazard_unit #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int TIMEOUT_CYCLES         = 16,
  parameter int COUNT_WIDTH            = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic                              ResultSrcE0_i,
  input  logic                              PCSrcE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteM_i,
  input  logic                              RegWriteW_i,
  input  logic                              MemReqM_i,
  input  logic                              MemReadyM_i,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              StallE_o,
  output logic                              StallM_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              FlushW_o,
  output logic                              MemTimeout_o,
  output logic [COUNT_WIDTH-1:0]            StallCount_o,
  output logic [COUNT_WIDTH-1:0]            FlushCount_o
);

  import hazard_pkg::*;

  localparam int AW = REGISTER_ADDRESS_WIDTH;
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

  hazard_state_t state;
  logic [WW-1:0] wait_cnt;
  logic          mem_wait;
  logic          lw_stall;
  logic          flush_inc;

  // Memory stage beats Writeback because it holds the younger value; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] rs,
    input logic [AW-1:0] rd_m,
    input logic          we_m,
    input logic [AW-1:0] rd_w,
    input logic          we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != '0) begin
      if (we_m && (rd_m == rs))      sel = FWD_M;
      else if (we_w && (rd_w == rs)) sel = FWD_W;
    end
    return sel;
  endfunction

  // Mealy on the handshake so the freeze starts in the very cycle the access misses.
  assign mem_wait = (MemReqM_i & ~MemReadyM_i) | (state == ERROR);

  // A taken branch squashes the dependent Decode instruction anyway, so no stall is needed.
  assign lw_stall = ResultSrcE0_i & (RdE_i != '0) &
                    ((RdE_i == Rs1D_i) | (RdE_i == Rs2D_i)) & ~PCSrcE_i;

  always_comb begin
    ForwardAE_o = FWD_RF;
    ForwardBE_o = FWD_RF;
    StallF_o    = 1'b0;
    StallD_o    = 1'b0;
    StallE_o    = 1'b0;
    StallM_o    = 1'b0;
    FlushD_o    = 1'b0;
    FlushE_o    = 1'b0;
    FlushW_o    = 1'b0;
    if (rst_i) begin
      // Clear D and E so no stale instruction survives reset.
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else begin
      ForwardAE_o = fwd_sel(Rs1E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
      ForwardBE_o = fwd_sel(Rs2E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
      if (mem_wait) begin
        // Freeze F..M; bubble W so the stalled M result is not retired twice.
        // Branch redirect is held off until E is released.
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        StallE_o = 1'b1;
        StallM_o = 1'b1;
        FlushW_o = 1'b1;
      end else begin
        StallF_o = lw_stall;
        StallD_o = lw_stall;
        FlushD_o = PCSrcE_i;
        FlushE_o = lw_stall | PCSrcE_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= RUN;
      wait_cnt     <= '0;
      MemTimeout_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= '0;
          if (MemReqM_i && !MemReadyM_i) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (MemReadyM_i) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_LAST) begin
              state        <= ERROR;
              MemTimeout_o <= 1'b1;
            end
          end
        end
        ERROR: begin
          MemTimeout_o <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign flush_inc = PCSrcE_i & ~mem_wait & ~rst_i;

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (StallF_o),
    .count_o (StallCount_o)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (flush_inc),
    .count_o (FlushCount_o)
  );

endmodule
